// File: rtl/eth_vlg_tmr_mc_if.sv
// Control/status bundle for the multi-channel timer. Control strobes are
// sampled on every rising clk edge; the timer has no ready and accepts every strobe.
interface eth_vlg_tmr_mc_if #(
  parameter int CHANNELS = 4,
  parameter int W        = 16
);
  logic                         tick_en;
  logic [CHANNELS-1:0]          start;
  logic [CHANNELS-1:0]          stop;
  logic [CHANNELS-1:0]          periodic;
  logic [CHANNELS-1:0][W-1:0]   period;
  logic [CHANNELS-1:0]          flag_clr;
  logic [CHANNELS-1:0]          busy;
  logic [CHANNELS-1:0]          expire;
  logic [CHANNELS-1:0]          flag;
  logic [CHANNELS-1:0][W-1:0]   ctr;
  logic [CHANNELS-1:0]          dbg_state;

  modport master (
    output tick_en, start, stop, periodic, period, flag_clr,
    input  busy, expire, flag, ctr, dbg_state
  );

  modport slave (
    input  tick_en, start, stop, periodic, period, flag_clr,
    output busy, expire, flag, ctr, dbg_state
  );
endinterface

// File: rtl/eth_vlg_tmr_mc.sv
// Multi-channel programmable down-counter timer sharing one prescaler.
// Each channel: IDLE/RUN FSM, one-shot or periodic, pulse and sticky expiry.
module eth_vlg_tmr_mc #(
  parameter int CHANNELS = 4,
  parameter int W        = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  eth_vlg_tmr_mc_if.slave  bus
);
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;

  logic [PW-1:0]              pre_q, pre_d;
  logic                       tick;
  logic [CHANNELS-1:0]        state_q, state_d;
  logic [CHANNELS-1:0]        mode_q, mode_d;
  logic [CHANNELS-1:0]        expire_q, expire_d;
  logic [CHANNELS-1:0]        flag_q, flag_d;
  logic [CHANNELS-1:0][W-1:0] ctr_q, ctr_d;

  // Free-running prescaler; never realigned by start.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (bus.tick_en) begin
      if (pre_q == PRE_LAST) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ctr_d    = ctr_q;
    expire_d = '0;
    flag_d   = flag_q & ~bus.flag_clr;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.stop[i]) begin
        state_d[i] = ST_IDLE;
        ctr_d[i]   = '0;
      end else if (bus.start[i]) begin
        // A zero period expires immediately without ever entering RUN.
        if (bus.period[i] == '0) begin
          state_d[i]  = ST_IDLE;
          ctr_d[i]    = '0;
          expire_d[i] = 1'b1;
        end else begin
          state_d[i] = ST_RUN;
          ctr_d[i]   = bus.period[i];
          mode_d[i]  = bus.periodic[i];
        end
      end else if (state_q[i] == ST_RUN && tick) begin
        if (ctr_q[i] != W'(1)) begin
          ctr_d[i] = ctr_q[i] - W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i] && bus.period[i] != '0) begin
            ctr_d[i]  = bus.period[i];
            mode_d[i] = bus.periodic[i];
          end else begin
            state_d[i] = ST_IDLE;
            ctr_d[i]   = '0;
          end
        end
      end
    end
    // Expiry outranks a coincident clear.
    flag_d = flag_d | expire_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q    <= '0;
      state_q  <= {CHANNELS{ST_IDLE}};
      mode_q   <= '0;
      expire_q <= '0;
      flag_q   <= '0;
      ctr_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      flag_q   <= flag_d;
      ctr_q    <= ctr_d;
    end
  end

  // RUN is encoded as 1, so the state vector is busy directly.
  assign bus.busy      = state_q;
  assign bus.dbg_state = state_q;
  assign bus.expire    = expire_q;
  assign bus.flag      = flag_q;
  assign bus.ctr       = ctr_q;
endmodule

// File: tb/tb_eth_vlg_tmr_mc.sv
// Bench for eth_vlg_tmr_mc: two instances (PRESCALE 1 and 4) share stimulus
// and are checked against a tick-counting reference model, a vector table and directed sequences.
module tb_eth_vlg_tmr_mc;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int P4 = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 tick_en;
  logic [CH-1:0]        start, stop, periodic, flag_clr;
  logic [CH-1:0][W-1:0] period;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];

  eth_vlg_tmr_mc_if #(.CHANNELS(CH), .W(W)) b1 ();
  eth_vlg_tmr_mc_if #(.CHANNELS(CH), .W(W)) b4 ();

  assign b1.tick_en  = tick_en;  assign b4.tick_en  = tick_en;
  assign b1.start    = start;    assign b4.start    = start;
  assign b1.stop     = stop;     assign b4.stop     = stop;
  assign b1.periodic = periodic; assign b4.periodic = periodic;
  assign b1.period   = period;   assign b4.period   = period;
  assign b1.flag_clr = flag_clr; assign b4.flag_clr = flag_clr;

  eth_vlg_tmr_mc #(.CHANNELS(CH), .W(W), .PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  eth_vlg_tmr_mc #(.CHANNELS(CH), .W(W), .PRESCALE(P4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_en  [2];
  bit m_run [2][CH];
  int m_rem [2][CH];
  bit m_per [2][CH];
  bit m_exp [2][CH];
  bit m_flag[2][CH];

  function automatic int pres(input int d);
    return (d == 0) ? 1 : P4;
  endfunction

  task automatic model_step(input int d);
    bit tk;
    bit e;
    int p;
    if (!rst_n) begin
      m_en[d] = 0;
      for (int c = 0; c < CH; c++) begin
        m_run[d][c] = 0; m_rem[d][c] = 0; m_per[d][c] = 0;
        m_exp[d][c] = 0; m_flag[d][c] = 0;
      end
      return;
    end
    // A tick lands on every pres-th enabled cycle since reset.
    tk = tick_en && (((m_en[d] + 1) % pres(d)) == 0);
    if (tick_en) m_en[d]++;
    for (int c = 0; c < CH; c++) begin
      e = 0;
      p = int'(period[c]);
      if (stop[c]) begin
        m_run[d][c] = 0; m_rem[d][c] = 0;
      end else if (start[c]) begin
        if (p == 0) begin
          e = 1; m_run[d][c] = 0; m_rem[d][c] = 0;
        end else begin
          m_run[d][c] = 1; m_rem[d][c] = p; m_per[d][c] = periodic[c];
        end
      end else if (m_run[d][c] && tk) begin
        m_rem[d][c]--;
        if (m_rem[d][c] == 0) begin
          e = 1;
          if (m_per[d][c] && p != 0) begin
            m_rem[d][c] = p; m_per[d][c] = periodic[c];
          end else begin
            m_run[d][c] = 0;
          end
        end
      end
      m_exp[d][c]  = e;
      m_flag[d][c] = e | (m_flag[d][c] & ~flag_clr[c]);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic compare_model(input int d);
    logic [CH-1:0]        eb, ee, ef;
    logic [CH-1:0][W-1:0] ec;
    for (int c = 0; c < CH; c++) begin
      eb[c] = m_run[d][c];
      ee[c] = m_exp[d][c];
      ef[c] = m_flag[d][c];
      ec[c] = W'(m_rem[d][c]);
    end
    if (d == 0) begin
      check("model_p1_busy",   64'(b1.busy),   64'(eb));
      check("model_p1_expire", 64'(b1.expire), 64'(ee));
      check("model_p1_flag",   64'(b1.flag),   64'(ef));
      check("model_p1_ctr",    64'(b1.ctr),    64'(ec));
    end else begin
      check("model_p4_busy",   64'(b4.busy),   64'(eb));
      check("model_p4_expire", 64'(b4.expire), 64'(ee));
      check("model_p4_flag",   64'(b4.flag),   64'(ef));
      check("model_p4_ctr",    64'(b4.ctr),    64'(ec));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    compare_model(0);
    compare_model(1);
  endtask

  task automatic idle_inputs();
    tick_en  = 1'b1;
    start    = '0;
    stop     = '0;
    periodic = '0;
    flag_clr = '0;
    period   = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic st, sp, per, fc, te;
    logic [W-1:0] p;
    logic busy, ex, fl;
    logic [W-1:0] c;
  } vec_t;

  vec_t vt[22];

  initial begin
    int gap, got, en, k, found, nexp;
    int first[CH];
    logic [W-1:0] hold;
    logic [W-1:0] pv[CH];

    rst_n = 1'b0;
    idle_inputs();

    //            st sp per fc te  p      busy ex fl  ctr
    vt[0]  = '{1, 0, 0, 0, 1, 16'd3,  1, 0, 0, 16'd3};
    vt[1]  = '{0, 0, 0, 0, 1, 16'd3,  1, 0, 0, 16'd2};
    vt[2]  = '{0, 0, 0, 0, 0, 16'd3,  1, 0, 0, 16'd2};
    vt[3]  = '{0, 0, 0, 0, 1, 16'd3,  1, 0, 0, 16'd1};
    vt[4]  = '{1, 0, 0, 0, 1, 16'd4,  1, 0, 0, 16'd4};
    vt[5]  = '{0, 0, 0, 0, 1, 16'd4,  1, 0, 0, 16'd3};
    vt[6]  = '{0, 0, 0, 0, 1, 16'd4,  1, 0, 0, 16'd2};
    vt[7]  = '{0, 0, 0, 0, 1, 16'd4,  1, 0, 0, 16'd1};
    vt[8]  = '{0, 0, 0, 1, 1, 16'd4,  0, 1, 1, 16'd0};
    vt[9]  = '{0, 0, 0, 0, 1, 16'd4,  0, 0, 1, 16'd0};
    vt[10] = '{0, 0, 0, 1, 1, 16'd4,  0, 0, 0, 16'd0};
    vt[11] = '{1, 0, 0, 0, 1, 16'd0,  0, 1, 1, 16'd0};
    vt[12] = '{0, 0, 0, 0, 1, 16'd0,  0, 0, 1, 16'd0};
    vt[13] = '{1, 1, 0, 0, 1, 16'd5,  0, 0, 1, 16'd0};
    vt[14] = '{1, 0, 1, 0, 1, 16'd2,  1, 0, 1, 16'd2};
    vt[15] = '{0, 0, 1, 0, 1, 16'd2,  1, 0, 1, 16'd1};
    vt[16] = '{0, 0, 1, 1, 1, 16'd2,  1, 1, 1, 16'd2};
    vt[17] = '{0, 0, 1, 1, 1, 16'd2,  1, 0, 0, 16'd1};
    vt[18] = '{0, 0, 1, 0, 1, 16'd2,  1, 1, 1, 16'd2};
    vt[19] = '{0, 1, 1, 0, 1, 16'd2,  0, 0, 1, 16'd0};
    vt[20] = '{1, 0, 1, 0, 1, 16'd0,  0, 1, 1, 16'd0};
    vt[21] = '{0, 0, 0, 1, 1, 16'd0,  0, 0, 0, 16'd0};

    // ---- reset with random inputs ----
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick_en  = 1'($urandom_range(0, 1));
      start    = CH'($urandom_range(0, 15));
      stop     = CH'($urandom_range(0, 15));
      periodic = CH'($urandom_range(0, 15));
      flag_clr = CH'($urandom_range(0, 15));
      for (int c = 0; c < CH; c++) period[c] = W'($urandom_range(0, 65535));
      cycle();
    end
    check("rst_busy",   64'(b1.busy),   64'd0);
    check("rst_expire", 64'(b1.expire), 64'd0);
    check("rst_flag",   64'(b1.flag),   64'd0);
    check("rst_ctr",    64'(b1.ctr),    64'd0);
    check("rst_state",  64'(b1.dbg_state), 64'd0);
    check("rst_p4_ctr", 64'(b4.ctr),    64'd0);
    rst_n = 1'b1;
    idle_inputs();

    // ---- one-shot P=5 on ch0 ----
    start[0] = 1'b1; period[0] = 16'd5;
    cycle();
    start = '0;
    check("os5_load_ctr", 64'(b1.ctr[0]), 64'd5);
    for (int t = 1; t <= 5; t++) begin
      cycle();
      check($sformatf("os5_expire_t%0d", t), 64'(b1.expire[0]), (t == 5) ? 64'd1 : 64'd0);
    end
    check("os5_busy_low", 64'(b1.busy[0]), 64'd0);
    check("os5_flag_set", 64'(b1.flag[0]), 64'd1);

    // ---- vector table on ch0 ----
    idle_inputs();
    do_reset(2);
    for (int i = 0; i < 22; i++) begin
      start[0]    = vt[i].st;
      stop[0]     = vt[i].sp;
      periodic[0] = vt[i].per;
      flag_clr[0] = vt[i].fc;
      tick_en     = vt[i].te;
      period[0]   = vt[i].p;
      cycle();
      check($sformatf("vec%0d_busy", i),   64'(b1.busy[0]),   64'(vt[i].busy));
      check($sformatf("vec%0d_expire", i), 64'(b1.expire[0]), 64'(vt[i].ex));
      check($sformatf("vec%0d_flag", i),   64'(b1.flag[0]),   64'(vt[i].fl));
      check($sformatf("vec%0d_ctr", i),    64'(b1.ctr[0]),    64'(vt[i].c));
    end
    idle_inputs();

    // ---- periodic ch1: P=3 for 10 periods, then P=4 after the next reload ----
    for (int n = 0; n < 11; n++) exp_q.push_back(W'(3));
    for (int n = 0; n < 3; n++)  exp_q.push_back(W'(4));
    start[1] = 1'b1; periodic[1] = 1'b1; period[1] = 16'd3;
    cycle();
    start = '0;
    for (int n = 0; n < 14; n++) begin
      gap = 0; got = 0;
      while (!got && gap < 20) begin
        cycle();
        gap++;
        if (b1.expire[1]) got = 1;
      end
      check($sformatf("per_gap%0d", n), 64'(gap), 64'(exp_q.pop_front()));
      if (n == 9) period[1] = 16'd4;
    end
    stop[1] = 1'b1;
    cycle();
    stop = '0;
    check("per_stop_ctr",  64'(b1.ctr[1]),  64'd0);
    check("per_stop_busy", 64'(b1.busy[1]), 64'd0);
    nexp = 0;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (b1.expire[1]) nexp++;
    end
    check("per_stop_no_expire", 64'(nexp), 64'd0);
    idle_inputs();

    // ---- prescaler 4, P=2 on ch2 with a 6-cycle tick_en gap ----
    start[2] = 1'b1; period[2] = 16'd2;
    cycle();
    start = '0;
    check("p4_load_ctr", 64'(b4.ctr[2]), 64'd2);
    en = 0; got = 0; k = 0; found = 0;
    while (!got && k < 40) begin
      if (en == 3 && !found) begin
        found   = 1;
        hold    = b4.ctr[2];
        tick_en = 1'b0;
        for (int t = 0; t < 6; t++) begin
          cycle();
          k++;
          check("p4_frozen_ctr", 64'(b4.ctr[2]), 64'(hold));
        end
        tick_en = 1'b1;
      end
      cycle();
      k++;
      en++;
      if (b4.expire[2]) got = 1;
    end
    check("p4_expired", 64'(got), 64'd1);
    check("p4_latency_in_range", 64'((en >= 5) && (en <= 8)), 64'd1);
    idle_inputs();

    // ---- reset mid-count on ch2 ----
    do_reset(1);
    start[2] = 1'b1; period[2] = 16'd10;
    cycle();
    start = '0;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      cycle();
      if (b1.ctr[2] == 16'd3) found = 1;
    end
    check("mid_rst_reached_3", 64'(found), 64'd1);
    do_reset(1);
    nexp = 0;
    for (int t = 0; t < 15; t++) begin
      cycle();
      if (b1.expire[2]) nexp++;
    end
    check("mid_rst_no_expire", 64'(nexp), 64'd0);
    check("mid_rst_flag",      64'(b1.flag[2]), 64'd0);

    // ---- randomized traffic against the model ----
    for (int t = 0; t < 2000; t++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      tick_en = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CH; c++) begin
        start[c]    = ($urandom_range(0, 7) == 0);
        stop[c]     = ($urandom_range(0, 23) == 0);
        flag_clr[c] = ($urandom_range(0, 5) == 0);
        periodic[c] = 1'($urandom_range(0, 1));
        period[c]   = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 12));
      end
      cycle();
    end
    rst_n = 1'b1;
    idle_inputs();

    // ---- four channels, P = 1, 2, 7, 2^W-1 ----
    do_reset(1);
    pv[0] = 16'd1; pv[1] = 16'd2; pv[2] = 16'd7; pv[3] = 16'hFFFF;
    for (int c = 0; c < CH; c++) begin
      period[c] = pv[c];
      first[c]  = -1;
    end
    start = '1;
    cycle();
    start = '0;
    found = 0;
    for (int t = 1; t <= 65540 && !found; t++) begin
      cycle();
      for (int c = 0; c < CH; c++)
        if (b1.expire[c] && first[c] < 0) first[c] = t;
      if (t == 65534) check("multi_ch3_ctr_before_end", 64'(b1.ctr[3]), 64'd1);
      found = (first[0] >= 0) && (first[1] >= 0) && (first[2] >= 0) && (first[3] >= 0);
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("multi_ch%0d_expire_cycle", c), 64'(first[c]), 64'(pv[c]));
    check("multi_ch3_ctr_end", 64'(b1.ctr[3]), 64'd0);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
